wb_reg_frontend: RTL and testbench
==================================

# wb_reg_frontend

Synthesizable Wishbone slave register front end of the I2C multi-bus controller. It sits directly downstream of the Wishbone master bus-functional driver and decodes its CSR/DPR/CMDR/FSMR accesses. It forwards accepted commands over a valid/ready handshake to the byte-level I2C FSM. It collects that FSM's completion status and raises the interrupt the driver waits on.

## Interface
- ADDR_WIDTH, 2: Wishbone address width. Register map: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
- DATA_WIDTH, 8: Wishbone data width.
- NUM_BUSES, 16: number of I2C buses; legal bus IDs are 0..NUM_BUSES-1.
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cyc_i, stb_i, we_i  in  1 each  Wishbone slave strobes.
- adr_i  in  ADDR_WIDTH  register select.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, valid while ack_o=1.
- ack_o  out  1  single-cycle transfer acknowledge.
- irq_o  out  1  level interrupt.
- cmd_valid_o  out  1  command offered to the byte FSM.
- cmd_ready_i  in  1  byte FSM accepts the command.
- cmd_o  out  3  command code.
- tx_data_o  out  8  DPR write value for WRITE and SET_BUS.
- rsp_valid_i  in  1  one-cycle completion pulse from the byte FSM.
- rsp_code_i  in  2  completion code: 00 done, 01 NAK, 10 arbitration lost, 11 error.
- rx_data_i  in  8  read byte; sampled when rsp_valid_i=1.
- bus_busy_i, bus_captured_i  in  1 each  I2C line status.
- fsm_state_i  in  8  {byte_state[3:0], bit_state[3:0]}, returned on FSMR reads.

## Operation
- CSR bit assignments:
  - [7] E (enable), [6] IE (interrupt enable): read/write.
  - [5] BB = bus_busy_i, [4] BC = bus_captured_i: read-only.
  - [3:0] current bus ID: read-only.
  - Writes update only bits 7:6.
- DPR:
  - Write stores tx_data.
  - Read returns rx_data, latched on the most recent completion that carried read data.
- CMDR reads return {DON, NAK, AL, ERR, 1'b0, last cmd[2:0]}.
- CMDR write, taken only when E=1:
  - Code 111 is invalid: ERR=1, DON=NAK=AL=0, irq per IE, no handshake.
  - SET_BUS (110) with DPR ≥ NUM_BUSES: same immediate ERR response.
  - Otherwise: clear DON/NAK/AL/ERR, set busy, assert cmd_valid_o with cmd_o=code and tx_data_o=DPR.
  - Command codes: 000 WAIT, 001 WRITE, 010 READ_ACK, 011 READ_NAK, 100 START, 101 STOP, 110 SET_BUS.
  - A CMDR write while busy=1, or while E=0, is acknowledged and ignored: no register change, no handshake.
- Completion: rsp_valid_i with busy=1:
  - Clear busy.
  - Set DON for code 00; set NAK, AL or ERR for codes 01, 10, 11.
  - Latch rx_data_i when the command was READ_ACK or READ_NAK.
  - Update bus ID from tx_data on SET_BUS done.
  - Set irq_o if IE=1.
  - rsp_valid_i while busy=0 is ignored.
- irq_o clears on any CMDR read.
- FSMR reads return fsm_state_i; FSMR writes are ignored.
- Disable (a CSR write with E=0):
  - Aborts any command: cmd_valid_o=0, busy=0.
  - irq_o=0; CMDR=0x80; DPR, rx_data and bus ID=0.
  - IE takes the written value.

## Timing
- Reset values:
  - Outputs: ack_o=0, dat_o=0, irq_o=0, cmd_valid_o=0, cmd_o=0, tx_data_o=0.
  - Registers: CSR=0x00, CMDR=0x80, bus ID=0, busy=0.
- ack_o:
  - Rises on the edge after cyc_i&stb_i is sampled with ack_o=0, so latency is 1 cycle.
  - Drops the next cycle.
  - A strobe held high across cycles yields one ack per 2 cycles.
- Writes take effect on the edge that raises ack_o; dat_o for reads is registered on that same edge.
- cmd_valid_o:
  - Rises on the CMDR write's ack edge.
  - Holds cmd_o and tx_data_o stable until sampled with cmd_ready_i=1, then falls the next edge.
  - busy stays 1 until the response.
- The earliest valid rsp_valid_i is the cycle after acceptance. Status, irq_o and rx_data update on that rsp_valid_i edge.
- Simultaneous events:
  - CMDR read and rsp_valid_i in the same cycle: dat_o returns the pre-update status and irq_o ends at 1 (set wins).
  - CSR disable and rsp_valid_i in the same cycle: disable wins and the response is dropped.
  - A CMDR write in the same cycle as rsp_valid_i is ignored, because busy is still 1.
- Reset asserted mid-transfer or mid-handshake forces all reset values immediately; no ack is issued for the interrupted access.

## Test plan
- Reset, then read CMDR and CSR: 0x80 and 0x00 returned; each ack_o arrives 1 cycle after stb_i; irq_o=0.
- Write CSR=0xC0, DPR=0x05, CMDR=0x06 with cmd_ready_i=1 and rsp 00:
  - cmd_valid_o is exactly 1 cycle with cmd_o=110 and tx_data_o=0x05.
  - irq_o rises; CMDR read returns 0x86 and drops irq_o; CSR[3:0]=5.
- READ_NAK (0x03) with rx_data_i=0xA5, rsp 00: DPR read returns 0xA5 and CMDR reads 0x83.
- WRITE with cmd_ready_i held low for 5 cycles:
  - cmd_valid_o stays high 5 cycles with data stable.
  - A second CMDR write meanwhile is ignored; rsp 01 then gives CMDR=0x41.
- Invalid code 0x07, and SET_BUS with DPR=0x10 (NUM_BUSES=16): immediate CMDR ERR (0x17, 0x16); irq_o=1; no cmd_valid_o.
- Outstanding START, then write CSR=0x00: cmd_valid_o and irq_o drop, CMDR=0x80, and a later rsp_valid_i is ignored.

Source files
------------

// File: rtl/wb_reg_frontend.sv
// Wishbone slave register front end for the I2C multi-bus controller.
// Decodes CSR/DPR/CMDR/FSMR accesses, forwards accepted commands to the
// byte-level I2C FSM over a valid/ready handshake, collects completion
// status and drives a level interrupt.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   cyc_i/stb_i/we_i/adr_i/dat_i/dat_o/ack_o : Wishbone slave, 1-cycle ack
//   irq_o                                     : level interrupt
//   cmd_valid_o/cmd_ready_i/cmd_o/tx_data_o   : command to byte FSM
//   rsp_valid_i/rsp_code_i/rx_data_i          : completion from byte FSM
//   bus_busy_i, bus_captured_i, fsm_state_i   : status for CSR/FSMR reads
module wb_reg_frontend #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUSES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_o,
  output logic [7:0]            tx_data_o,
  input  logic                  rsp_valid_i,
  input  logic [1:0]            rsp_code_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  bus_busy_i,
  input  logic                  bus_captured_i,
  input  logic [7:0]            fsm_state_i
);

  typedef enum logic [1:0] {REG_CSR, REG_DPR, REG_CMDR, REG_FSMR} reg_e;
  typedef enum logic [2:0] {
    CMD_WAIT, CMD_WRITE, CMD_READ_ACK, CMD_READ_NAK,
    CMD_START, CMD_STOP, CMD_SET_BUS, CMD_INVALID
  } cmd_e;

  localparam logic [8:0] NB = 9'(NUM_BUSES);

  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  e_q, e_d, ie_q, ie_d;
  logic [3:0]            bus_id_q, bus_id_d;
  logic [7:0]            dpr_q, dpr_d, rx_q, rx_d, tx_q, tx_d;
  logic [3:0]            stat_q, stat_d;     // {DON, NAK, AL, ERR}
  cmd_e                  last_cmd_q, last_cmd_d;
  logic                  busy_q, busy_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  irq_q, irq_d;

  logic acc, rd, wr;
  reg_e sel;
  cmd_e wcmd;

  always_comb begin
    acc  = cyc_i & stb_i & ~ack_q;
    rd   = acc & ~we_i;
    wr   = acc & we_i;
    sel  = reg_e'(adr_i[1:0]);
    wcmd = cmd_e'(dat_i[2:0]);

    ack_d       = acc;
    dat_d       = '0;
    e_d         = e_q;
    ie_d        = ie_q;
    bus_id_d    = bus_id_q;
    dpr_d       = dpr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    stat_d      = stat_q;
    last_cmd_d  = last_cmd_q;
    busy_d      = busy_q;
    cmd_valid_d = cmd_valid_q;
    irq_d       = irq_q;

    // Read data reflects register contents before this edge's updates.
    if (rd) begin
      unique case (sel)
        REG_CSR:  dat_d = DATA_WIDTH'({e_q, ie_q, bus_busy_i, bus_captured_i, bus_id_q});
        REG_DPR:  dat_d = DATA_WIDTH'(rx_q);
        REG_CMDR: dat_d = DATA_WIDTH'({stat_q, 1'b0, last_cmd_q});
        REG_FSMR: dat_d = DATA_WIDTH'(fsm_state_i);
      endcase
    end

    if (cmd_valid_q && cmd_ready_i) cmd_valid_d = 1'b0;

    // Clear-on-read is applied before completion so a same-cycle set wins.
    if (rd && sel == REG_CMDR) irq_d = 1'b0;

    if (rsp_valid_i && busy_q) begin
      busy_d      = 1'b0;
      cmd_valid_d = 1'b0;
      stat_d      = 4'b1000 >> rsp_code_i;
      if (last_cmd_q == CMD_READ_ACK || last_cmd_q == CMD_READ_NAK) rx_d = rx_data_i;
      if (last_cmd_q == CMD_SET_BUS && rsp_code_i == 2'b00) bus_id_d = tx_q[3:0];
      if (ie_q) irq_d = 1'b1;
    end

    // Register writes come last so a disable overrides a same-cycle completion.
    if (wr) begin
      unique case (sel)
        REG_CSR: begin
          if (dat_i[7]) begin
            e_d  = 1'b1;
            ie_d = dat_i[6];
          end else begin
            e_d         = 1'b0;
            ie_d        = dat_i[6];
            cmd_valid_d = 1'b0;
            busy_d      = 1'b0;
            irq_d       = 1'b0;
            stat_d      = 4'b1000;
            last_cmd_d  = CMD_WAIT;
            dpr_d       = '0;
            rx_d        = '0;
            tx_d        = '0;
            bus_id_d    = '0;
          end
        end
        REG_DPR: dpr_d = dat_i[7:0];
        REG_CMDR: begin
          if (e_q && !busy_q) begin
            last_cmd_d = wcmd;
            if (wcmd == CMD_INVALID || (wcmd == CMD_SET_BUS && {1'b0, dpr_q} >= NB)) begin
              stat_d = 4'b0001;
              if (ie_q) irq_d = 1'b1;
            end else begin
              stat_d      = '0;
              busy_d      = 1'b1;
              cmd_valid_d = 1'b1;
              tx_d        = dpr_q;
            end
          end
        end
        REG_FSMR: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      e_q         <= 1'b0;
      ie_q        <= 1'b0;
      bus_id_q    <= '0;
      dpr_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      stat_q      <= 4'b1000;
      last_cmd_q  <= CMD_WAIT;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      e_q         <= e_d;
      ie_q        <= ie_d;
      bus_id_q    <= bus_id_d;
      dpr_q       <= dpr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      stat_q      <= stat_d;
      last_cmd_q  <= last_cmd_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign ack_o       = ack_q;
  assign dat_o       = dat_q;
  assign irq_o       = irq_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = last_cmd_q;
  assign tx_data_o   = tx_q;

endmodule

// File: tb/tb_wb_reg_frontend.sv
module tb_wb_reg_frontend;
  localparam int NBUS = 16;
  localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2, A_FSMR = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_w, dat_r;
  logic       ack, irq, cmd_valid, cmd_ready;
  logic [2:0] cmd;
  logic [7:0] tx_data;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic [7:0] rx_data;
  logic       bb, bc;
  logic [7:0] fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_reg_frontend #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_BUSES(NBUS)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_w),
    .dat_o(dat_r), .ack_o(ack), .irq_o(irq),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_o(cmd), .tx_data_o(tx_data),
    .rsp_valid_i(rsp_valid), .rsp_code_i(rsp_code), .rx_data_i(rx_data),
    .bus_busy_i(bb), .bus_captured_i(bc), .fsm_state_i(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; returns at the falling edge after the ack edge.
  task automatic wb(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    chk("ack_idle", ack, 1'b0);
    @(posedge clk); #1;
    chk("ack_latency", ack, 1'b1);
    rd = dat_r;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Called at a falling edge: one-cycle completion pulse.
  task automatic pulse_rsp(input logic [1:0] c, input logic [7:0] rx);
    rsp_valid = 1'b1; rsp_code = c; rx_data = rx;
    @(negedge clk);
    rsp_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  initial begin
    logic [7:0] r, d, rxv;
    logic [7:0] m_dpr, m_rx, m_cmdr;
    logic [3:0] m_bus;
    logic       m_ie, m_irq, imm;
    int unsigned code, rc, dly, sel;

    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_code = 0; rx_data = 0;
    bb = 0; bc = 0; fsm_state = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);       chk("rst_dat", dat_r, 0);
    chk("rst_irq", irq, 0);       chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);       chk("rst_tx", tx_data, 0);
    rst_n = 1'b1;

    // Reset register values
    wb(0, A_CMDR, 0, r); chk("rst_cmdr", r, 8'h80);
    wb(0, A_CSR, 0, r);  chk("rst_csr", r, 8'h00);
    chk("rst_irq2", irq, 0);

    // SET_BUS 5 with immediate acceptance
    wb(1, A_CSR, 8'hC0, r);
    wb(1, A_DPR, 8'h05, r);
    cmd_ready = 1'b1;
    wb(1, A_CMDR, 8'h06, r);
    chk("sb_valid", cmd_valid, 1); chk("sb_cmd", cmd, 3'b110); chk("sb_tx", tx_data, 8'h05);
    @(negedge clk);
    chk("sb_valid_1cyc", cmd_valid, 0);
    pulse_rsp(2'b00, 8'h00);
    chk("sb_irq", irq, 1);
    wb(0, A_CMDR, 0, r); chk("sb_cmdr", r, 8'h86);
    chk("sb_irq_clr", irq, 0);
    wb(0, A_CSR, 0, r);  chk("sb_csr", r, 8'hC5);

    // READ_NAK returns data
    rxv = 8'($urandom);
    wb(1, A_CMDR, 8'h03, r);
    @(negedge clk);
    pulse_rsp(2'b00, rxv);
    wb(0, A_DPR, 0, r);  chk("rn_dpr", r, rxv);
    wb(0, A_CMDR, 0, r); chk("rn_cmdr", r, 8'h83);

    // WRITE held off by cmd_ready for 5 cycles, second CMDR write ignored
    cmd_ready = 1'b0;
    d = 8'($urandom);
    wb(1, A_DPR, d, r);
    wb(1, A_CMDR, 8'h01, r);
    chk("wr_valid_c1", cmd_valid, 1);
    wb(1, A_CMDR, 8'h02, r);
    chk("wr_valid_c3", cmd_valid, 1); chk("wr_cmd_hold", cmd, 3'b001); chk("wr_tx_hold", tx_data, d);
    repeat (2) begin
      @(negedge clk);
      chk("wr_valid_hold", cmd_valid, 1); chk("wr_cmd_hold", cmd, 3'b001); chk("wr_tx_hold", tx_data, d);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("wr_valid_fall", cmd_valid, 0);
    cmd_ready = 1'b0;
    pulse_rsp(2'b01, 8'h00);
    wb(0, A_CMDR, 0, r); chk("wr_cmdr_nak", r, 8'h41);

    // Immediate errors
    wb(1, A_CMDR, 8'h07, r);
    chk("inv_novalid", cmd_valid, 0); chk("inv_irq", irq, 1);
    wb(0, A_CMDR, 0, r); chk("inv_cmdr", r, 8'h17);
    wb(1, A_DPR, 8'h10, r);
    wb(1, A_CMDR, 8'h06, r);
    chk("sbbad_novalid", cmd_valid, 0); chk("sbbad_irq", irq, 1);
    wb(0, A_CMDR, 0, r); chk("sbbad_cmdr", r, 8'h16);

    // CMDR read in the same cycle as the completion
    cmd_ready = 1'b1;
    wb(1, A_CMDR, 8'h04, r);
    @(negedge clk);
    cmd_ready = 1'b0;
    cyc = 1; stb = 1; we = 0; adr = A_CMDR;
    rsp_valid = 1; rsp_code = 2'b00;
    @(posedge clk); #1;
    chk("sim_ack", ack, 1); chk("sim_dat_pre", dat_r, 8'h04); chk("sim_irq_set_wins", irq, 1);
    @(negedge clk);
    cyc = 0; stb = 0; rsp_valid = 0;
    wb(0, A_CMDR, 0, r); chk("sim_cmdr_post", r, 8'h84);

    // Disable aborts an outstanding START
    wb(1, A_CMDR, 8'h07, r);
    chk("dis_pre_irq", irq, 1);
    wb(1, A_CMDR, 8'h04, r);
    chk("dis_pre_valid", cmd_valid, 1);
    wb(1, A_CSR, 8'h00, r);
    chk("dis_valid", cmd_valid, 0); chk("dis_irq", irq, 0);
    pulse_rsp(2'b00, 8'h5A);
    chk("dis_rsp_ign_irq", irq, 0);
    wb(0, A_CMDR, 0, r); chk("dis_cmdr", r, 8'h80);
    wb(0, A_CSR, 0, r);  chk("dis_csr", r, 8'h00);
    wb(0, A_DPR, 0, r);  chk("dis_dpr", r, 8'h00);
    wb(1, A_CMDR, 8'h01, r);
    chk("dis_cmd_ign_valid", cmd_valid, 0);
    wb(0, A_CMDR, 0, r); chk("dis_cmd_ign_cmdr", r, 8'h80);

    // Disable in the same cycle as a completion: disable wins
    wb(1, A_CSR, 8'hC0, r);
    cmd_ready = 1'b1;
    wb(1, A_CMDR, 8'h05, r);
    @(negedge clk);
    cmd_ready = 1'b0;
    cyc = 1; stb = 1; we = 1; adr = A_CSR; dat_w = 8'h40;
    rsp_valid = 1; rsp_code = 2'b00;
    @(posedge clk); #1;
    chk("dr_ack", ack, 1);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; rsp_valid = 0;
    chk("dr_irq", irq, 0);
    wb(0, A_CMDR, 0, r); chk("dr_cmdr", r, 8'h80);
    wb(0, A_CSR, 0, r);  chk("dr_csr", r, 8'h40);

    // Randomized commands against the reference model
    wb(1, A_CSR, 8'hC0, r);
    m_ie = 1; m_bus = 0; m_rx = 0; m_dpr = 0; m_cmdr = 8'h80; m_irq = 0;
    for (int i = 0; i < 40; i++) begin
      bb = 1'($urandom); bc = 1'($urandom); fsm_state = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        m_ie = 1'($urandom);
        wb(1, A_CSR, {1'b1, m_ie, 6'($urandom)}, r);
      end
      m_dpr = 8'($urandom_range(0, 20));
      wb(1, A_DPR, m_dpr, r);
      code = $urandom_range(0, 7);
      imm  = (code == 7) || (code == 6 && m_dpr >= NBUS);
      wb(1, A_CMDR, 8'(code), r);
      if (imm) begin
        chk("rnd_imm_novalid", cmd_valid, 0);
        m_cmdr = 8'h10 | 8'(code);
        if (m_ie) m_irq = 1;
      end else begin
        chk("rnd_valid", cmd_valid, 1); chk("rnd_cmd", cmd, 3'(code)); chk("rnd_tx", tx_data, m_dpr);
        dly = $urandom_range(0, 3);
        repeat (dly) begin
          @(negedge clk);
          chk("rnd_valid_hold", cmd_valid, 1); chk("rnd_tx_hold", tx_data, m_dpr);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("rnd_valid_fall", cmd_valid, 0);
        rc  = $urandom_range(0, 3);
        rxv = 8'($urandom);
        pulse_rsp(2'(rc), rxv);
        m_cmdr = (8'h80 >> rc) | 8'(code);
        if (code == 2 || code == 3) m_rx = rxv;
        if (code == 6 && rc == 0) m_bus = m_dpr[3:0];
        if (m_ie) m_irq = 1;
      end
      chk("rnd_irq", irq, m_irq);
      sel = $urandom_range(0, 3);
      wb(0, 2'(sel), 0, r);
      case (sel)
        0: chk("rnd_csr", r, {1'b1, m_ie, bb, bc, m_bus});
        1: chk("rnd_dpr", r, m_rx);
        2: begin chk("rnd_cmdr", r, m_cmdr); m_irq = 0; end
        default: chk("rnd_fsmr", r, fsm_state);
      endcase
      chk("rnd_irq_after_read", irq, m_irq);
    end

    // Reset asserted mid-handshake and mid-transfer
    bb = 0; bc = 0;
    wb(1, A_CMDR, 8'h01, r);
    chk("mr_pre_valid", cmd_valid, 1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = A_CSR;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ack", ack, 0); chk("mr_valid", cmd_valid, 0); chk("mr_irq", irq, 0);
    chk("mr_cmd", cmd, 0); chk("mr_tx", tx_data, 0);
    @(posedge clk); #1;
    chk("mr_no_ack", ack, 0); chk("mr_dat", dat_r, 0);
    @(negedge clk);
    cyc = 0; stb = 0;
    rst_n = 1'b1;
    wb(0, A_CMDR, 0, r); chk("mr_cmdr", r, 8'h80);
    wb(0, A_CSR, 0, r);  chk("mr_csr", r, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
